// File: rtl/vic4_responder.sv
// rtl/vic4_responder.sv - four-channel vectored interrupt responder (virq/istb/iack/ivec handshake)
// Optional round-robin arbitration: define VIC4_ROUNDROBIN_EN.
module vic4_responder #(
    parameter logic [15:0] V0 = 16'o000060,
    parameter logic [15:0] V1 = 16'o000064,
    parameter logic [15:0] V2 = 16'o000100,
    parameter logic [15:0] V3 = 16'o000120
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [3:0]  ireq,
    output logic [3:0]  dev_ack,
    output logic        virq,
    input  logic        istb,
    output logic        iack,
    output logic [15:0] ivec
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  winner_q, winner_d;
    logic [1:0]  arb_win;
    logic        virq_q, virq_d;
    logic        iack_q, iack_d;
    logic [15:0] ivec_q, ivec_d;
    logic [3:0]  dev_ack_q, dev_ack_d;

    function automatic logic [15:0] vec_of(input logic [1:0] ch);
        case (ch)
            2'd0:    vec_of = V0;
            2'd1:    vec_of = V1;
            2'd2:    vec_of = V2;
            default: vec_of = V3;
        endcase
    endfunction

`ifdef VIC4_ROUNDROBIN_EN
    logic [1:0] ptr_q, ptr_d;

    // Walk the search order backwards so the first candidate after ptr wins.
    always_comb begin
        arb_win = ptr_q;
        for (int k = 4; k >= 1; k--) begin
            if (ireq[ptr_q + 2'(k)]) begin
                arb_win = ptr_q + 2'(k);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == REQ && istb) begin
            ptr_d = winner_q;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ptr_q <= 2'd3;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        arb_win = 2'd3;
        if (ireq[0]) begin
            arb_win = 2'd0;
        end else if (ireq[1]) begin
            arb_win = 2'd1;
        end else if (ireq[2]) begin
            arb_win = 2'd2;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        virq_d    = virq_q;
        iack_d    = iack_q;
        ivec_d    = ivec_q;
        dev_ack_d = 4'b0000;
        case (state_q)
            IDLE: begin
                if (|ireq) begin
                    winner_d = arb_win;
                    virq_d   = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                // istb takes precedence over a request withdrawn on the same edge.
                if (istb) begin
                    iack_d              = 1'b1;
                    ivec_d              = vec_of(winner_q);
                    dev_ack_d[winner_q] = 1'b1;
                    state_d             = ACK;
                end else if (!ireq[winner_q]) begin
                    virq_d  = 1'b0;
                    state_d = GAP;
                end
            end
            ACK: begin
                if (!istb) begin
                    iack_d  = 1'b0;
                    ivec_d  = 16'd0;
                    virq_d  = 1'b0;
                    state_d = GAP;
                end
            end
            default: begin
                virq_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            winner_q  <= 2'd0;
            virq_q    <= 1'b0;
            iack_q    <= 1'b0;
            ivec_q    <= 16'd0;
            dev_ack_q <= 4'b0000;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            virq_q    <= virq_d;
            iack_q    <= iack_d;
            ivec_q    <= ivec_d;
            dev_ack_q <= dev_ack_d;
        end
    end

    assign virq    = virq_q;
    assign iack    = iack_q;
    assign ivec    = ivec_q;
    assign dev_ack = dev_ack_q;

endmodule
